// File: rtl/ctrl_interrupcao_pkg.sv
// ctrl_interrupcao_pkg: shared sizes, FSM state encoding and a small helper
// for the four-source interrupt controller.
package ctrl_interrupcao_pkg;

  localparam int unsigned N_SRC  = 4;
  localparam int unsigned ID_W   = 2;
  localparam int unsigned CONT_W = 8;

  // Handshake state; 2'b11 is unused and recovers to OCIOSO.
  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    PEDIDO  = 2'b01,
    SERVICO = 2'b10
  } estado_t;

  // One-hot decode of a source index.
  function automatic logic [N_SRC-1:0] onehot_src(input logic [ID_W-1:0] idx);
    logic [N_SRC-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/ctrl_interrupcao_codpri4.sv
// codpri4: 4-to-2 priority encoder with enable, purely combinational.
// Ports:
//   i  in  4  request vector, bit 3 has highest priority
//   en in  1  enable; when low the output is 0
//   y  out 2  index of the highest set bit of i (0 when i==0 or en==0)
module codpri4
  import ctrl_interrupcao_pkg::*;
(
  input  logic [N_SRC-1:0] i,
  input  logic             en,
  output logic [ID_W-1:0]  y
);

  // Highest index wins.
  always_comb begin
    y = '0;
    if (en) begin
      if (i[3])      y = ID_W'(3);
      else if (i[2]) y = ID_W'(2);
      else if (i[1]) y = ID_W'(1);
      else           y = ID_W'(0);
    end
  end

endmodule

// File: rtl/ctrl_interrupcao.sv
// ctrl_interrupcao: four-source interrupt controller. Latches rising edges of
// req into pend, applies a programmable mask, selects the highest-index
// unmasked pending source and runs an irq/ack/eoi handshake with the consumer.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   req[3:0]         request lines (rising edge raises a source)
//   wr_msk, msk_in   mask load strobe and value (1 = masked)
//   ack              consumer accepts the current request (PEDIDO only)
//   eoi              consumer ends service (SERVICO only)
//   irq              request to consumer (registered)
//   id[1:0]          index of requested/serviced source (registered)
//   ocupado          service in progress (registered)
//   pend[3:0]        pending register
//   cont[7:0]        accepted-request counter, wraps
module ctrl_interrupcao
  import ctrl_interrupcao_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_SRC-1:0]  req,
  input  logic              wr_msk,
  input  logic [N_SRC-1:0]  msk_in,
  input  logic              ack,
  input  logic              eoi,
  output logic              irq,
  output logic [ID_W-1:0]   id,
  output logic              ocupado,
  output logic [N_SRC-1:0]  pend,
  output logic [CONT_W-1:0] cont
);

  estado_t           estado;
  logic [N_SRC-1:0]  req_q;
  logic [N_SRC-1:0]  msk;
  logic [N_SRC-1:0]  sel;
  logic [N_SRC-1:0]  subida;
  logic [N_SRC-1:0]  limpa;
  logic [N_SRC-1:0]  pend_nxt;
  logic [ID_W-1:0]   cod_y;
  logic              aceita;

  assign sel    = pend & ~msk;
  assign subida = req & ~req_q;
  assign aceita = (estado == PEDIDO) && ack;

  codpri4 u_codpri4 (
    .i  (sel),
    .en (1'b1),
    .y  (cod_y)
  );

  // Clear the accepted source; a new edge in the same cycle takes precedence.
  always_comb begin
    limpa    = '0;
    if (aceita) limpa = onehot_src(id);
    pend_nxt = (pend & ~limpa) | subida;
  end

  // State, handshake outputs and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado  <= OCIOSO;
      irq     <= 1'b0;
      id      <= '0;
      ocupado <= 1'b0;
      pend    <= '0;
      req_q   <= '0;
      msk     <= '0;
      cont    <= '0;
    end else begin
      req_q <= req;
      pend  <= pend_nxt;
      if (wr_msk) msk <= msk_in;

      case (estado)
        OCIOSO: begin
          irq     <= 1'b0;
          ocupado <= 1'b0;
          if (sel != '0) begin
            estado <= PEDIDO;
            irq    <= 1'b1;
            id     <= cod_y;
          end
        end
        PEDIDO: begin
          // id stays frozen until the consumer accepts.
          if (ack) begin
            estado  <= SERVICO;
            irq     <= 1'b0;
            ocupado <= 1'b1;
            cont    <= cont + CONT_W'(1);
          end
        end
        SERVICO: begin
          if (eoi) begin
            estado  <= OCIOSO;
            ocupado <= 1'b0;
          end
        end
        default: begin
          estado  <= OCIOSO;
          irq     <= 1'b0;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_interrupcao.sv
// tb_ctrl_interrupcao: directed bench for ctrl_interrupcao with
// hand-computed expected values.
module tb_ctrl_interrupcao;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       wr_msk;
  logic [3:0] msk_in;
  logic       ack;
  logic       eoi;
  logic       irq;
  logic [1:0] id;
  logic       ocupado;
  logic [3:0] pend;
  logic [7:0] cont;

  int n_chk;
  int n_ok;

  ctrl_interrupcao dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .wr_msk  (wr_msk),
    .msk_in  (msk_in),
    .ack     (ack),
    .eoi     (eoi),
    .irq     (irq),
    .id      (id),
    .ocupado (ocupado),
    .pend    (pend),
    .cont    (cont)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (obs === exp) n_ok = n_ok + 1;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic do_eoi();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_ok   = 0;
    rst_n  = 1'b0;
    req    = 4'b0000;
    wr_msk = 1'b0;
    msk_in = 4'b0000;
    ack    = 1'b0;
    eoi    = 1'b0;

    #12;
    chk("rst_irq",     32'(irq),     0);
    chk("rst_id",      32'(id),      0);
    chk("rst_ocupado", 32'(ocupado), 0);
    chk("rst_pend",    32'(pend),    0);
    chk("rst_cont",    32'(cont),    0);
    rst_n = 1'b1;
    tick();

    // Single source 2.
    req = 4'b0100;
    tick();
    chk("s1_pend_e0", 32'(pend), 'b0100);
    chk("s1_irq_e0",  32'(irq),  0);
    tick();
    chk("s1_irq_e1",  32'(irq),  1);
    chk("s1_id",      32'(id),   2);
    do_ack();
    chk("s1_ack_irq", 32'(irq),     0);
    chk("s1_ack_oc",  32'(ocupado), 1);
    chk("s1_ack_pnd", 32'(pend),    0);
    chk("s1_cont",    32'(cont),    1);
    do_eoi();
    chk("s1_eoi_oc",  32'(ocupado), 0);
    chk("s1_eoi_irq", 32'(irq),     0);
    req = 4'b0000;
    tick();
    chk("s1_idle_irq", 32'(irq), 0);

    // Priority among 3, 1, 0.
    req = 4'b1011;
    tick();
    chk("pr_pend", 32'(pend), 'b1011);
    req = 4'b0000;
    tick();
    chk("pr_id3", 32'(id), 3);
    do_ack();
    do_eoi();
    tick();
    chk("pr_irq1", 32'(irq), 1);
    chk("pr_id1",  32'(id),  1);
    do_ack();
    do_eoi();
    tick();
    chk("pr_id0", 32'(id), 0);
    do_ack();
    chk("pr_cont", 32'(cont), 4);
    chk("pr_pend0", 32'(pend), 0);
    do_eoi();
    tick();
    chk("pr_idle", 32'(irq), 0);

    // Mask source 3.
    wr_msk = 1'b1;
    msk_in = 4'b1000;
    tick();
    wr_msk = 1'b0;
    req = 4'b1001;
    tick();
    chk("mk_pend", 32'(pend), 'b1001);
    req = 4'b0000;
    tick();
    chk("mk_irq", 32'(irq), 1);
    chk("mk_id0", 32'(id),  0);
    do_ack();
    chk("mk_pend3", 32'(pend), 'b1000);
    wr_msk = 1'b1;
    msk_in = 4'b0000;
    do_eoi();
    wr_msk = 1'b0;
    chk("mk_gap_irq", 32'(irq), 0);
    tick();
    chk("mk_irq3", 32'(irq), 1);
    chk("mk_id3",  32'(id),  3);
    do_ack();
    chk("mk_cont", 32'(cont), 6);
    do_eoi();
    tick();

    // No preemption; held level on req[1].
    req = 4'b0010;
    tick();
    tick();
    chk("np_irq", 32'(irq), 1);
    chk("np_id1", 32'(id),  1);
    req = 4'b1010;
    tick();
    chk("np_pend", 32'(pend), 'b1010);
    tick();
    chk("np_frozen", 32'(id), 1);
    do_ack();
    chk("np_pend3", 32'(pend), 'b1000);
    do_eoi();
    tick();
    chk("np_id3", 32'(id), 3);
    do_ack();
    chk("np_cont", 32'(cont), 8);
    do_eoi();
    for (int k = 0; k < 4; k++) tick();
    chk("hl_irq",  32'(irq),  0);
    chk("hl_pend", 32'(pend), 0);
    req = 4'b0000;
    tick();

    // Simultaneous set/clear on source 2.
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tick();
    chk("sc_id", 32'(id), 2);
    ack = 1'b1;
    req = 4'b0100;
    tick();
    ack = 1'b0;
    chk("sc_pend", 32'(pend),    'b0100);
    chk("sc_oc",   32'(ocupado), 1);
    chk("sc_cont", 32'(cont),    9);
    do_eoi();
    tick();
    chk("sc_irq", 32'(irq), 1);
    chk("sc_id2", 32'(id),  2);
    req = 4'b0000;

    // Reset during SERVICO with a pending source.
    ack = 1'b1;
    req = 4'b0001;
    tick();
    ack = 1'b0;
    chk("rm_oc_pre",   32'(ocupado), 1);
    chk("rm_pend_pre", 32'(pend),    'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm_oc",   32'(ocupado), 0);
    chk("rm_irq",  32'(irq),     0);
    chk("rm_pend", 32'(pend),    0);
    chk("rm_cont", 32'(cont),    0);
    req = 4'b0000;
    #2;
    rst_n = 1'b1;
    tick();

    // Counter wrap after 256 services.
    for (int n = 0; n < 256; n++) begin
      req = 4'b0001;
      tick();
      req = 4'b0000;
      tick();
      do_ack();
      if (n == 254) chk("wr_cont255", 32'(cont), 255);
      do_eoi();
    end
    chk("wr_cont0", 32'(cont), 0);
    chk("wr_oc",    32'(ocupado), 0);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
